dm_responder: RTL and testbench

Data-memory responder for the multi-cycle and pipelined CPU variants: it sits on the far end of the CPU's data-memory port and services word loads and byte-enabled stores through a valid/ready request/response handshake with configurable wait states. It also handles out-of-range and misaligned accesses, and zero-fills its storage after reset. CPU load/store units act as initiators toward this block.

---
 rtl/dm_responder.sv | 191 +++++++++++++++++++
 tb/tb_dm_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the CPU load/store port.
// Services word loads and byte-enabled stores over a valid/ready
// request/response handshake with LATENCY wait cycles. Misaligned or
// out-of-range accesses return rsp_err=1. Storage is zero-filled after reset.
// Optional build macro: DM_TRACE_EN prints one trace line per committed store.
module dm_responder #(
    parameter int DEPTH   = 3072,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  LAT_M1     = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_q, clr_d;
    logic [3:0]        wait_q, wait_d;

    // Captured request (data only; meaningful once the FSM leaves IDLE)
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;

    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem_q [DEPTH];

    // Access currently being resolved: with LATENCY=0 the commit edge is the
    // accept edge itself, so the live request is used while still in IDLE.
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic              accept;
    logic              enter_resp;

`ifdef DM_TRACE_EN
    logic [31:0]       pc_q;
    logic [31:0]       acc_pc;
`else
    logic              unused_pc;
    assign unused_pc = ^req_pc;
`endif

    // Select live vs captured request and derive error, index and merged word
    always_comb begin
        accept    = (state_q == S_IDLE) && req_valid;
        acc_we    = (state_q == S_IDLE) ? req_we    : we_q;
        acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
        acc_be    = (state_q == S_IDLE) ? req_be    : be_q;
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
        acc_idx   = acc_addr[IDX_W+1:2];
        cur_word  = mem_q[acc_idx];
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = acc_be[i] ? acc_wdata[8*i +: 8] : cur_word[8*i +: 8];
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        wait_d    = wait_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                clr_d = clr_q + IDX_W'(1);
                if (clr_q == LAST_IDX) begin
                    clr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wait_d  = LAT_M1;
                    state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    end

    // Control state register; reset restarts the zero-fill and drops any pending access
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_CLEAR;
            clr_q   <= '0;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            wait_q  <= wait_d;
        end
    end

    // Capture the request on the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
`ifdef DM_TRACE_EN
            pc_q    <= req_pc;
`endif
        end
    end

`ifdef DM_TRACE_EN
    assign acc_pc = (state_q == S_IDLE) ? req_pc : pc_q;
`endif

    // Storage: zero-fill during CLEAR, commit stores on the edge entering RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_q == S_CLEAR) begin
                mem_q[clr_q] <= 32'd0;
            end else if (enter_resp && acc_we && !acc_err) begin
                mem_q[acc_idx] <= merged;
`ifdef DM_TRACE_EN
                if (acc_be != 4'b0000) begin
                    $display("@%h: *%h <= %h", acc_pc, {acc_addr[31:2], 2'b00}, merged);
                end
`endif
            end
        end
    end

    // Response data: sampled entering RESP, held while stalled, cleared on leaving
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (acc_we || acc_err) ? 32'd0 : cur_word;
            err_q   <= acc_err;
        end else if ((state_q == S_RESP) && rsp_ready) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed, table-driven bench for dm_responder (DEPTH=16, LATENCY=2).
module tb_dm_responder;

    localparam int DEPTH   = 16;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count edges after reset release until req_ready rises; also count rsp_valid highs.
    task automatic wait_clear(input string name);
        int n = 0;
        int v = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) v++;
        end
        check({name, "_clear_cycles"}, n, DEPTH);
        check({name, "_no_rsp_valid"}, v, 0);
    endtask

    // Issue one request; optionally complete the handshake with rsp_ready=1.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit handshake,
                       output logic [31:0] rdata, output logic err);
        int n = 0;
        int lat = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_pc    = 32'h0000_1000 + addr;
        @(posedge clk); #1;
        // Garbage on request inputs after accept must be ignored.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        check("req_ready_low_after_accept", req_ready, 0);
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        // rsp_valid becomes visible LATENCY edges after the accept edge,
        // i.e. it is sampled high at edge T+LATENCY+1.
        check("rsp_latency", lat, LATENCY);
        rdata = rsp_rdata;
        err   = rsp_err;
        if (handshake) begin
            @(posedge clk); #1;
            check("post_hs_rsp_valid", rsp_valid, 0);
            check("post_hs_req_ready", req_ready, 1);
            check("post_hs_rdata_clr", rsp_rdata, 0);
            check("post_hs_err_clr", rsp_err, 0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] held;

        vecs[0]  = '{1'b0, 32'h0000_003C, 32'h0,         4'hF,    32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF,    32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0,    32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0,    32'h12BB_56DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0,         4'hF,    32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF,    32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_003C, 32'h1122_3344, 4'b1000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0,    32'h1100_0000, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0,    32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0,    32'h12BB_56DD, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0007, 32'h5555_5555, 4'hF,    32'h0000_0000, 1'b1};
        vecs[13] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0,    32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    32'h0000_0000, 1'b1};

        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        req_pc    = 32'h0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        reset = 1'b1;
        wait_clear("init");

        // Table of single transactions, each with rsp_ready held high
        for (int i = 0; i < 15; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b1, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
        end

        // Backpressure: response must hold for 5 stalled cycles
        rsp_ready = 1'b0;
        txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b0, rd, er);
        check("bp_rdata", rd, 32'h12BB_56DD);
        held = rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_valid_c%0d", c), rsp_valid, 1);
            check($sformatf("bp_rdata_c%0d", c), rsp_rdata, held);
            check($sformatf("bp_ready_c%0d", c), req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", req_ready, 1);
        check("bp_release_valid", rsp_valid, 0);
        check("bp_release_rdata", rsp_rdata, 0);

        // Reset during WAIT of a store: store must be dropped
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        check("midrst_hold_valid", rsp_valid, 0);
        reset = 1'b1;
        wait_clear("midrst");
        txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b1, rd, er);
        check("midrst_load4_rdata", rd, 32'h0);
        check("midrst_load4_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b1, rd, er);
        check("midrst_load8_cleared", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
